pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 64'h100, redirect address for misaligned targets (used only with PC_MISALIGN_TRAP_EN).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 stall  in  1  hazard-unit hold request for the PC.
REQ-006 br_taken  in  1  branch/jump resolved taken in EX.
REQ-007 br_target  in  64  redirect address, valid with br_taken.
REQ-008 imem_ready  in  1  instruction memory accepts the current request.
REQ-009 imem_req  out  1  fetch request valid.
REQ-010 imem_addr  out  64  fetch address; always equals pc_out.
REQ-011 pc_out  out  64  PC of the instruction in IF.
REQ-012 flush  out  1  kill the IF/ID instruction this cycle.
REQ-013 misalign_err  out  1  one-cycle pulse on misaligned redirect (tied 0 without PC_MISALIGN_TRAP_EN).

Function
REQ-014 FSM states BOOT, RUN, HOLD; state and PC held in registers.
REQ-015 BOOT: imem_req=0, PC=RESET_VECTOR, all inputs ignored, flush=0; unconditionally to RUN next cycle.
REQ-016 RUN and HOLD: imem_req=1.
REQ-017 Next-PC priority in RUN/HOLD: br_taken > stall > !imem_ready > sequential.
REQ-018 br_taken=1: PC <= br_target, flush=1 combinationally in the same cycle, next state RUN; overrides stall and !imem_ready.
REQ-019 br_taken=0 and stall=1: PC unchanged, flush=0, next state HOLD.
REQ-020 br_taken=0, stall=0, imem_ready=0: PC unchanged, next state HOLD.
REQ-021 br_taken=0, stall=0, imem_ready=1: PC <= PC+4, next state RUN.
REQ-022 PC+4 computed modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC advances to 64'h0 without error.
REQ-023 One redirect per cycle; br_taken on consecutive cycles each redirect and each assert flush.
REQ-024 flush=0 whenever br_taken=0 or state=BOOT.
REQ-025 PC changes only on accepted fetch (imem_ready=1) or redirect; the address is never advanced without acceptance.

Reset
REQ-026 reset=0 immediately forces state=BOOT, PC=RESET_VECTOR, imem_req=0, flush=0, misalign_err=0, independent of clk.
REQ-027 Reset asserted mid-stall, mid-HOLD or during br_taken discards all pending state; no redirect survives reset.
REQ-028 After reset deassertion, exactly one BOOT cycle precedes the first imem_req=1 at RESET_VECTOR.

Configuration
REQ-029 Macro PC_MISALIGN_TRAP_EN compiles in target alignment checking.
REQ-030 Defined: br_taken=1 with br_target[1:0]!=0 loads TRAP_VECTOR instead of br_target, asserts flush and misalign_err for that cycle.
REQ-031 Undefined: br_target loaded unmodified regardless of alignment; misalign_err constant 0; no checking logic present.

Verification
REQ-032 Release reset with RESET_VECTOR=0, stall=0, imem_ready=1 -> cycle 1 imem_req=0, then imem_addr 0x0, 0x4, 0x8, 0xC on successive cycles.
REQ-033 PC=0x10, imem_ready=0 for 3 cycles, then 1 -> imem_addr held 0x10 for 4 cycles, then 0x14.
REQ-034 PC=0x20, stall=1 and br_taken=1 with br_target=0x400 in the same cycle -> flush=1 that cycle, next imem_addr=0x400.
REQ-035 PC=0xFFFF_FFFF_FFFF_FFFC, imem_ready=1 -> next PC 0x0, misalign_err=0.
REQ-036 With PC_MISALIGN_TRAP_EN, br_taken=1, br_target=0x402 -> flush=1, misalign_err=1 one cycle, next PC=0x100; without macro -> next PC=0x402, misalign_err=0.
REQ-037 reset=0 asserted between clock edges while in HOLD at PC=0x80 -> pc_out=RESET_VECTOR and imem_req=0 before the next edge; BOOT cycle repeats after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: BOOT/RUN/HOLD sequencer with branch redirect and flush.
// Define PC_MISALIGN_TRAP_EN to send misaligned redirect targets to TRAP_VECTOR.
module pc_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] TRAP_VECTOR  = 64'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [63:0] pc_out,
  output logic        flush,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pc_nxt;
  logic [63:0] redirect;
  logic        misalign;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = (br_target[1:0] != 2'b00);
  assign redirect = misalign ? TRAP_VECTOR : br_target;
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign misalign = 1'b0;
  assign redirect = br_target;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Redirect wins over stall and over an unaccepted fetch; the PC only
  // advances when the current request has been accepted.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    imem_req     = 1'b0;
    flush        = 1'b0;
    misalign_err = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        pc_nxt    = RESET_VECTOR;
      end
      RUN, HOLD: begin
        imem_req = 1'b1;
        if (br_taken) begin
          pc_nxt       = redirect;
          flush        = 1'b1;
          misalign_err = misalign;
          state_nxt    = RUN;
        end else if (stall || !imem_ready) begin
          state_nxt = HOLD;
        end else begin
          pc_nxt    = pc + 64'd4;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
        pc_nxt    = RESET_VECTOR;
      end
    endcase
  end

  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, corner sequences, random run vs reference model.
module tb_pc_sequencer;
  localparam logic [63:0] RV = 64'h0;
  localparam logic [63:0] TV = 64'h100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'h0;
  logic        imem_ready = 1'b0;
  logic        imem_req, flush, misalign_err;
  logic [63:0] imem_addr, pc_out;

  int total = 0;
  int bad = 0;

  bit          m_boot;
  logic [63:0] m_pc;

  typedef struct {
    bit          s;
    bit          b;
    bit          r;
    logic [63:0] tgt;
    logic [63:0] addr;
    bit          req;
    bit          fl;
  } vec_t;
  vec_t tbl[15];

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc_out(pc_out), .flush(flush),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", n, a, e, $time);
    end
  endtask

  task automatic chk64(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic vec_t mk(bit s, bit b, bit r, logic [63:0] tgt,
                              logic [63:0] addr, bit req, bit fl);
    vec_t v;
    v.s = s; v.b = b; v.r = r; v.tgt = tgt; v.addr = addr; v.req = req; v.fl = fl;
    return v;
  endfunction

  // Drive inputs just after a rising edge, then move to the falling edge to sample.
  task automatic cycle(input bit s, input bit b, input bit r, input logic [63:0] t);
    stall = s; br_taken = b; imem_ready = r; br_target = t;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_pc   = RV;
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_boot) m_boot = 1'b0;
    else if (br_taken) m_pc = (TRAP && br_target[1:0] != 2'b00) ? TV : br_target;
    else if (!stall && imem_ready) m_pc = m_pc + 64'd4;
    #1;
  endtask

  task automatic model_check();
    bit ef;
    ef = !m_boot && br_taken;
    chk1("rnd_req", imem_req, !m_boot);
    chk64("rnd_addr", imem_addr, m_pc);
    chk64("rnd_pc_out", pc_out, m_pc);
    chk1("rnd_flush", flush, ef);
    chk1("rnd_misalign", misalign_err, ef && TRAP && (br_target[1:0] != 2'b00));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] t;
    tbl[0]  = mk(0, 1, 1, 64'h500, 64'h0,   0, 0);
    tbl[1]  = mk(0, 0, 1, 64'h0,   64'h0,   1, 0);
    tbl[2]  = mk(0, 0, 1, 64'h0,   64'h4,   1, 0);
    tbl[3]  = mk(0, 0, 1, 64'h0,   64'h8,   1, 0);
    tbl[4]  = mk(0, 0, 1, 64'h0,   64'hC,   1, 0);
    tbl[5]  = mk(0, 0, 0, 64'h0,   64'h10,  1, 0);
    tbl[6]  = mk(0, 0, 0, 64'h0,   64'h10,  1, 0);
    tbl[7]  = mk(0, 0, 0, 64'h0,   64'h10,  1, 0);
    tbl[8]  = mk(0, 0, 1, 64'h0,   64'h10,  1, 0);
    tbl[9]  = mk(1, 0, 1, 64'h0,   64'h14,  1, 0);
    tbl[10] = mk(1, 1, 1, 64'h20,  64'h14,  1, 1);
    tbl[11] = mk(1, 1, 0, 64'h400, 64'h20,  1, 1);
    tbl[12] = mk(0, 1, 0, 64'h408, 64'h400, 1, 1);
    tbl[13] = mk(0, 0, 1, 64'h0,   64'h408, 1, 0);
    tbl[14] = mk(0, 0, 0, 64'h0,   64'h40C, 1, 0);

    // Reset held with a branch on the inputs: nothing may leak through.
    br_taken = 1'b1; br_target = 64'h500; imem_ready = 1'b1;
    #12;
    chk1("rst_req", imem_req, 1'b0);
    chk64("rst_addr", imem_addr, RV);
    chk1("rst_flush", flush, 1'b0);
    chk1("rst_misalign", misalign_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].s, tbl[i].b, tbl[i].r, tbl[i].tgt);
      chk64($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
      chk1($sformatf("vec%0d_req", i), imem_req, tbl[i].req);
      chk1($sformatf("vec%0d_flush", i), flush, tbl[i].fl);
      chk1($sformatf("vec%0d_misalign", i), misalign_err, 1'b0);
      advance();
    end

    // Wrap-around of the sequential increment.
    cycle(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    cycle(0, 0, 1, 64'h0);
    chk64("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk1("wrap_misalign", misalign_err, 1'b0);
    advance();
    cycle(0, 0, 1, 64'h0);
    chk64("wrap_addr_zero", imem_addr, 64'h0);
    advance();

    // Misaligned redirect target.
    cycle(0, 1, 0, 64'h402);
    chk1("mis_flush", flush, 1'b1);
    chk1("mis_err", misalign_err, TRAP);
    advance();
    cycle(0, 0, 0, 64'h0);
    chk64("mis_next_pc", imem_addr, TRAP ? TV : 64'h402);
    chk1("mis_err_pulse", misalign_err, 1'b0);
    advance();

    // Asynchronous reset mid-cycle while holding at 0x80 with a branch pending.
    cycle(0, 1, 1, 64'h80);
    advance();
    cycle(0, 0, 0, 64'h0);
    advance();
    #1;
    chk64("hold_addr", imem_addr, 64'h80);
    br_taken = 1'b1; br_target = 64'h900;
    #1;
    chk1("hold_br_flush", flush, 1'b1);
    reset = 1'b0;
    #1;
    chk64("async_addr", pc_out, RV);
    chk1("async_req", imem_req, 1'b0);
    chk1("async_flush", flush, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    cycle(0, 0, 1, 64'h0);
    chk1("reboot_req", imem_req, 1'b0);
    advance();
    cycle(0, 0, 1, 64'h0);
    chk1("restart_req", imem_req, 1'b1);
    chk64("restart_addr", imem_addr, RV);
    advance();

    for (int i = 0; i < 400; i++) begin
      t = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, t);
      model_check();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
